acl_spi_reader: RTL and testbench

- SPI master that initialises the ADXL362 accelerometer and samples X/Y/Z periodically.
- Packs each axis into a 5-bit signed field and produces the 15-bit `acl_data` word consumed by the game logic: X in [14:10], Y in [9:5], Z in [4:0].
- Sits between the board accelerometer pins and the game core, in the 100 MHz clock domain.

---
 rtl/acl_spi_reader.sv | 198 +++++++++++++++++++
 tb/tb_acl_spi_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acl_spi_reader.sv
// ADXL362 SPI master: writes POWER_CTL once after startup, then periodically
// reads X/Y/Z and packs raw[11:7] of each axis into a 15-bit word.
module acl_spi_reader #(
    parameter int unsigned HALF_DIV       = 50,
    parameter int unsigned STARTUP_CYCLES = 1_000_000,
    parameter int unsigned SAMPLE_PERIOD  = 10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic [14:0] acl_data,
    output logic        data_valid
);

    localparam int unsigned CNT_MAX = (STARTUP_CYCLES > 2 * HALF_DIV) ? STARTUP_CYCLES
                                                                      : 2 * HALF_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DIV_W   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int unsigned TMR_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(2 * HALF_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(HALF_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST     = TMR_W'(SAMPLE_PERIOD - 1);

    // Half-period index of the final SCLK-low phase (2 * bit count).
    localparam logic [7:0]  CFG_HALF_LAST  = 8'd48;
    localparam logic [7:0]  READ_HALF_LAST = 8'd128;
    localparam logic [63:0] CFG_FRAME      = {24'h0A_2D_02, 40'h0};
    localparam logic [63:0] READ_FRAME     = {16'h0B_0E, 48'h0};

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_CFG,
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_GAP
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       half_q, half_d;
    logic [63:0]      tx_q, tx_d;
    logic [47:0]      rx_q, rx_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             tmr_run_q, tmr_run_d;
    logic             pend_q, pend_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic [14:0]      acl_q, acl_d;
    logic             dv_q, dv_d;

    logic             in_xfer;
    logic             div_wrap;
    logic             frame_end;
    logic             tick;
    logic [7:0]       half_last;
    logic [14:0]      packed_xyz;

    assign in_xfer   = (state_q == ST_CFG) || (state_q == ST_READ);
    assign div_wrap  = (div_q == DIV_LAST);
    assign half_last = (state_q == ST_CFG) ? CFG_HALF_LAST : READ_HALF_LAST;
    assign frame_end = in_xfer && div_wrap && (half_q == half_last);
    assign tick      = tmr_run_q && (tmr_q == TMR_LAST);

    // rx_q holds XL,XH,YL,YH,ZL,ZH from MSB down; field = {H[3:0], L[7]}.
    assign packed_xyz = {rx_q[35:32], rx_q[47],
                         rx_q[19:16], rx_q[31],
                         rx_q[3:0],   rx_q[15]};

    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            state_q <= ST_STARTUP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            ST_STARTUP: if (cnt_q == STARTUP_LAST) state_d = ST_CFG;
            ST_CFG:     if (frame_end)             state_d = ST_GAP;
            ST_IDLE:    if (tick || pend_q)        state_d = ST_READ;
            ST_READ:    if (frame_end)             state_d = ST_LATCH;
            ST_LATCH:                              state_d = ST_GAP;
            ST_GAP:     if (cnt_q == GAP_LAST)     state_d = ST_IDLE;
            default:                               state_d = ST_STARTUP;
        endcase
    end

    always_comb begin : datapath
        cnt_d  = '0;
        div_d  = '0;
        half_d = '0;
        tx_d   = tx_q;
        rx_d   = rx_q;

        if ((state_q == ST_STARTUP || state_q == ST_GAP) && state_d == state_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_d != state_q) begin
            if (state_d == ST_CFG)  tx_d = CFG_FRAME;
            if (state_d == ST_READ) tx_d = READ_FRAME;
        end else if (in_xfer) begin
            if (div_wrap) begin
                half_d = half_q + 8'd1;
                // Odd half-periods are SCLK high: sample on the rise, shift on the fall.
                if (half_d[0]) begin
                    if (state_q == ST_READ) rx_d = {rx_q[46:0], miso};
                end else begin
                    tx_d = {tx_q[62:0], 1'b0};
                end
            end else begin
                div_d  = div_q + DIV_W'(1);
                half_d = half_q;
            end
        end
    end

    always_comb begin : sample_timer
        tmr_run_d = tmr_run_q || (state_d == ST_IDLE);
        tmr_d     = '0;
        if (tmr_run_q) begin
            tmr_d = tick ? '0 : tmr_q + TMR_W'(1);
        end
        pend_d = pend_q;
        if (state_q == ST_IDLE && state_d == ST_READ) begin
            pend_d = 1'b0;
        end else if (tick && state_q != ST_IDLE) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin : output_logic
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        dv_d   = 1'b0;
        acl_d  = acl_q;
        if (state_d == ST_CFG || state_d == ST_READ) begin
            cs_n_d = 1'b0;
            sclk_d = half_d[0];
            mosi_d = tx_d[63];
        end
        if (state_d == ST_LATCH) begin
            dv_d  = 1'b1;
            acl_d = packed_xyz;
        end
    end

    always_ff @(posedge clk) begin : data_regs
        if (!rst_n) begin
            cnt_q     <= '0;
            div_q     <= '0;
            half_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            tmr_q     <= '0;
            tmr_run_q <= 1'b0;
            pend_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            acl_q     <= '0;
            dv_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            half_q    <= half_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            tmr_q     <= tmr_d;
            tmr_run_q <= tmr_run_d;
            pend_q    <= pend_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            acl_q     <= acl_d;
            dv_q      <= dv_d;
        end
    end

    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign cs_n       = cs_n_q;
    assign acl_data   = acl_q;
    assign data_valid = dv_q;

endmodule

// File: tb/tb_acl_spi_reader.sv
// Bench for acl_spi_reader: an SPI slave/monitor checks framing and timing,
// and a byte-level model predicts every packed sample.
module tb_acl_spi_reader;

    localparam int unsigned HALF_DIV       = 2;
    localparam int unsigned STARTUP_CYCLES = 100;
    localparam int unsigned SAMPLE_PERIOD  = 1000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        miso  = 1'b0;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic [14:0] acl_data;
    logic        data_valid;

    acl_spi_reader #(
        .HALF_DIV      (HALF_DIV),
        .STARTUP_CYCLES(STARTUP_CYCLES),
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .acl_data  (acl_data),
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Each axis: 16-bit little-endian, sign-extended 12-bit value; field = raw[11:7].
    function automatic logic [14:0] model_acl(input logic [47:0] v);
        int acc;
        int lo;
        int hi;
        int raw;
        acc = 0;
        for (int a = 0; a < 3; a++) begin
            lo  = int'((v >> (8 * (5 - 2 * a))) & 48'hFF);
            hi  = int'((v >> (8 * (4 - 2 * a))) & 48'hFF);
            raw = hi * 256 + lo;
            acc = acc * 32 + (raw % 4096) / 128;
        end
        return 15'(acc);
    endfunction

    function automatic logic [15:0] rand_axis();
        int v;
        v = int'($urandom_range(0, 4095));
        if (v >= 2048) v = v - 4096;
        return 16'(v);
    endfunction

    // Slave bytes for the next read: XL,XH,YL,YH,ZL,ZH.
    logic [47:0] rd_vec = 48'h0;

    int unsigned cyc = 0;
    int unsigned rel_cnt = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;
    logic        prev_dv = 1'b0;
    logic [14:0] prev_acl = '0;
    int          frame_idx = 0;
    logic        in_frame = 1'b0;
    logic        frame_is_cfg = 1'b0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int unsigned cs_fall_cyc = 0;
    int unsigned cs_rise_cyc = 0;
    int unsigned last_rise_cyc = 0;
    int unsigned last_fall_cyc = 0;
    int unsigned last_mosi_cyc = 0;
    int unsigned last_read_fall = 0;
    logic        have_read_fall = 1'b0;
    logic [63:0] mosi_acc = '0;
    logic [63:0] frame_vec = '0;
    logic [47:0] done_vec = '0;
    logic        dv_expected = 1'b0;
    int          sclk_err = 0;
    int          mosi_err = 0;
    int          idle_err = 0;
    int          dv_err = 0;
    int          hold_err = 0;
    int          n_reads = 0;
    int          n_dv = 0;
    int          n_cfg = 0;

    always begin : spi_monitor
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            rel_cnt        = 0;
            frame_idx      = 0;
            in_frame       = 1'b0;
            dv_expected    = 1'b0;
            have_read_fall = 1'b0;
            sclk_err       = 0;
            mosi_err       = 0;
            miso           = 1'b0;
        end else begin
            rel_cnt++;
            if (prev_cs && !cs_n) begin
                frame_is_cfg = (frame_idx == 0);
                if (frame_is_cfg) begin
                    check("startup_delay", 64'(rel_cnt), 64'(STARTUP_CYCLES));
                    frame_vec = '0;
                end else begin
                    check("cs_gap", 64'((cyc - cs_rise_cyc) >= 2 * HALF_DIV), 64'd1);
                    check("dv_before_next_read", 64'(dv_expected), 64'd0);
                    if (have_read_fall)
                        check("read_period", 64'(cyc - last_read_fall), 64'(SAMPLE_PERIOD));
                    have_read_fall = 1'b1;
                    last_read_fall = cyc;
                    frame_vec = {16'h0, rd_vec};
                end
                frame_idx++;
                in_frame    = 1'b1;
                rise_cnt    = 0;
                fall_cnt    = 0;
                mosi_acc    = '0;
                cs_fall_cyc = cyc;
                miso        = frame_vec[63];
            end
            if (in_frame && !prev_sclk && sclk) begin
                if (rise_cnt == 0) begin
                    if (cyc - cs_fall_cyc != HALF_DIV) sclk_err++;
                end else if (cyc - last_rise_cyc != 2 * HALF_DIV) begin
                    sclk_err++;
                end
                if (cyc - last_mosi_cyc < HALF_DIV) mosi_err++;
                mosi_acc      = {mosi_acc[62:0], mosi};
                rise_cnt++;
                last_rise_cyc = cyc;
            end
            if (in_frame && prev_sclk && !sclk) begin
                if (cyc - last_rise_cyc != HALF_DIV) sclk_err++;
                fall_cnt++;
                last_fall_cyc = cyc;
                miso = (fall_cnt < 64) ? frame_vec[63 - fall_cnt] : 1'b0;
            end
            if (in_frame && mosi !== prev_mosi) begin
                if (rise_cnt > 0 && cyc - last_rise_cyc < HALF_DIV) mosi_err++;
                last_mosi_cyc = cyc;
            end
            if (cs_n && sclk) idle_err++;
            if (in_frame && !prev_cs && cs_n) begin
                in_frame    = 1'b0;
                cs_rise_cyc = cyc;
                miso        = 1'b0;
                check("cs_after_fall", 64'(cyc - last_fall_cyc), 64'(HALF_DIV));
                if (frame_is_cfg) begin
                    check("cfg_rises", 64'(rise_cnt), 64'd24);
                    check("cfg_bytes", {40'h0, mosi_acc[23:0]}, 64'h0A_2D_02);
                    n_cfg++;
                end else begin
                    check("read_rises", 64'(rise_cnt), 64'd64);
                    check("read_bytes", mosi_acc, 64'h0B0E_0000_0000_0000);
                    n_reads++;
                    dv_expected = 1'b1;
                    done_vec    = frame_vec[47:0];
                end
                check("sclk_timing", 64'(sclk_err), 64'd0);
                check("mosi_stable", 64'(mosi_err), 64'd0);
                sclk_err = 0;
                mosi_err = 0;
            end
            if (data_valid) begin
                n_dv++;
                check("dv_after_read", 64'(dv_expected), 64'd1);
                check("acl_model", 64'(acl_data), 64'(model_acl(done_vec)));
                dv_expected = 1'b0;
                if (prev_dv) dv_err++;
            end else if (acl_data !== prev_acl) begin
                hold_err++;
            end
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_dv   = data_valid;
        prev_acl  = acl_data;
    end

    task automatic wait_dv(input int target, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (n_dv < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("dv_arrival", 64'(n_dv), 64'(target));
    endtask

    task automatic new_sample();
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        x = rand_axis();
        y = rand_axis();
        z = rand_axis();
        rd_vec = {x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8]};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, 64'(cs_n), 64'd1);
        check({tag, "_sclk"}, 64'(sclk), 64'd0);
        check({tag, "_acl"},  64'(acl_data), 64'd0);
        check({tag, "_dv"},   64'(data_valid), 64'd0);
    endtask

    initial begin : stimulus
        int unsigned n;
        rst_n  = 1'b0;
        rd_vec = {8'h00, 8'h03, 8'h00, 8'hFD, 8'hE8, 8'h03};
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");

        @(negedge clk);
        rst_n = 1'b1;
        wait_dv(1, 3000);
        check("spec_vector_acl", 64'(acl_data), 64'h1B47);

        for (int r = 2; r <= 5; r++) begin
            new_sample();
            wait_dv(r, 1500);
        end
        new_sample();

        n = 0;
        while (!(in_frame && !frame_is_cfg && rise_cnt >= 28) && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("reach_read_byte4", 64'(in_frame && !frame_is_cfg && rise_cnt >= 28), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        check_reset_outputs("abort");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        new_sample();
        wait_dv(6, 3000);

        check("cfg_count", 64'(n_cfg), 64'd2);
        check("dv_per_read", 64'(n_dv), 64'(n_reads));
        check("dv_single_cycle", 64'(dv_err), 64'd0);
        check("acl_hold", 64'(hold_err), 64'd0);
        check("sclk_idle_low", 64'(idle_err), 64'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
